banked_dp_ram: RTL and testbench
================================

# banked_dp_ram

Parametrised banked simple-dual-port RAM: one write port and one read port, both on `clk`. Storage is `NUM_BANKS` banks of `2**WORD_ADDR_W` words each. The upper address bits select a bank and the lower bits select a word. It is the next generation of the fixed 4x1K 12-bit banked memory and adds:
- a registered read with a valid flag,
- write-first forwarding on same-address collisions,
- out-of-range address detection,
- a hardware clear sequence after reset.

It sits between the memory-access front end and the data path wherever counted or buffered data is stored.

## Interface
Parameters:
- `DATA_W`, default 12, word width in bits.
- `WORD_ADDR_W`, default 10, word-address bits per bank. Bank depth `DEPTH = 2**WORD_ADDR_W`.
- `NUM_BANKS`, default 4, number of banks, range 1..16.
- `ADDR_W`, localparam, equals `WORD_ADDR_W + max(1, $clog2(NUM_BANKS))`. Default 12.

Ports:
- `clk`, input, 1 bit. Single clock; all logic is on the rising edge.
- `rst`, input, 1 bit. Asynchronous, active-high reset.
- `data_in`, input, `DATA_W` bits. Write data.
- `write_address`, input, `ADDR_W` bits. Bits `[ADDR_W-1:WORD_ADDR_W]` are the bank index; the lower bits are the word index.
- `write_enable`, input, 1 bit. Write request, sampled every cycle.
- `read_address`, input, `ADDR_W` bits. Same split as `write_address`.
- `read_enable`, input, 1 bit. Read request, sampled every cycle.
- `data_out`, output, `DATA_W` bits. Registered read data.
- `data_valid`, output, 1 bit. One-cycle pulse: `data_out` holds a fresh read result.
- `init_busy`, output, 1 bit. High while the clear sequence runs; requests are ignored while it is high.
- `wr_err`, output, 1 bit. One-cycle pulse: the previous-cycle write targeted a bank index `>= NUM_BANKS`.
- `rd_err`, output, 1 bit. One-cycle pulse: the previous-cycle read targeted a bank index `>= NUM_BANKS`.
- `collision_count`, output, 16 bits. Saturating count of same-address read/write collisions.

## Operation
- **Controller FSM**, three states:
  - `RESET`: entered while `rst` is high.
  - `CLEAR`: entered when `rst` falls.
  - `READY`: normal operation.
- **`CLEAR` state:**
  - A `WORD_ADDR_W`-bit counter starts at 0.
  - Each cycle the block writes 0 to word `counter` in every bank in parallel, then increments the counter.
  - After word `DEPTH-1` is cleared, the FSM moves to `READY`.
  - `init_busy` = 1 in `RESET` and `CLEAR`, 0 in `READY`.
- **Requests during `init_busy`:** `write_enable` and `read_enable` are ignored. No memory update, no `data_valid`, no error pulse, no count change.
- **Write in `READY`:** `write_enable=1` with a valid bank index writes `data_in` into bank[bank index], word[word index]. An invalid bank index drops the write and sets `wr_err` on the next cycle.
- **Read in `READY`:** `read_enable=1` with a valid bank index loads the addressed word into `data_out` and sets `data_valid` on the next cycle. An invalid bank index sets `rd_err` on the next cycle, leaves `data_valid=0`, and holds `data_out`.
- **Collision:** a valid read and a valid write to the identical full address in the same cycle is write-first.
  - `data_out` takes `data_in` of that cycle.
  - Memory is updated.
  - `collision_count` increments, saturating at 16'hFFFF.
- **Same-bank reads and writes to different words** in the same cycle proceed independently; there is no stall.
- **`data_out` between reads** holds its last value; it is not cleared.
- **Non-power-of-two `NUM_BANKS`:** bank indices from `NUM_BANKS` to `2**clog2-1` are invalid. With `NUM_BANKS=1`, the single bank-select bit must be 0.

## Timing
- **Reset values** (asynchronous, while `rst` = 1): `data_out`=0, `data_valid`=0, `wr_err`=0, `rd_err`=0, `collision_count`=0, `init_busy`=1, clear counter=0.
- **Clear duration:** the first clear write occurs on the first rising edge after `rst` falls. `init_busy` falls after exactly `DEPTH` edges, i.e. 1024 cycles at the defaults.
- **Reset during `CLEAR`:** `rst` asserted mid-clear returns the FSM to `RESET`, and the clear restarts from word 0 on release.
- **Read latency:** 1 cycle. A request sampled at edge N produces `data_out`, `data_valid` or `rd_err` valid after edge N, for the whole of cycle N+1.
- **Write visibility:** a write sampled at edge N is readable by a read sampled at edge N+1. A read at edge N itself sees the write through the collision path.
- **Throughput:** one read and one write per cycle sustained, with no back-pressure.
- **Pulse width:** `data_valid`, `wr_err` and `rd_err` are each high for exactly one cycle per request.

## Test plan
1. **Reset and clear:** assert `rst` for 3 cycles, release.
   - `init_busy` stays 1 for exactly 1024 cycles, then 0.
   - Reading address 12'h7FF returns 0 with `data_valid=1` one cycle later.
2. **Write/read across banks:** write 12'hABC to 12'h005 and 12'h123 to 12'hC05; then read both.
   - `data_out` = 12'hABC, then 12'h123, each with a 1-cycle `data_valid` pulse. Banks 0 and 3 are independent.
3. **Collision:** with 12'h010 holding 12'h111, in one cycle write 12'h222 to 12'h010 and read 12'h010.
   - Next cycle `data_out`=12'h222 and `collision_count`=1.
   - A following read also returns 12'h222.
4. **Invalid bank** (`NUM_BANKS=3`): write to 12'hC00.
   - `wr_err` pulses; a read of 12'hC00 gives `rd_err=1`, `data_valid=0`, and `data_out` unchanged.
   - Bank 0 word 0 is unmodified.
5. **Requests during clear:** issue a write and a read at cycle 10 after reset release.
   - No `data_valid`, no error pulse.
   - After clear completes, the target word reads 0.
6. **Reset mid-clear and saturation:**
   - Assert `rst` at clear cycle 500; `init_busy` is then high for the full 1024 cycles after release.
   - Separately, force 65537 collisions; `collision_count` holds 16'hFFFF.

Source files
------------

// File: rtl/banked_dp_ram_if.sv
// Request/response bundle for banked_dp_ram: one write port, one read port,
// plus the status outputs. Clock and reset travel as plain ports.
interface banked_dp_ram_if #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 12
);
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] write_address;
  logic              write_enable;
  logic [ADDR_W-1:0] read_address;
  logic              read_enable;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              init_busy;
  logic              wr_err;
  logic              rd_err;
  logic [15:0]       collision_count;

  modport master (
    output data_in, write_address, write_enable, read_address, read_enable,
    input  data_out, data_valid, init_busy, wr_err, rd_err, collision_count
  );

  modport slave (
    input  data_in, write_address, write_enable, read_address, read_enable,
    output data_out, data_valid, init_busy, wr_err, rd_err, collision_count
  );
endinterface

// File: rtl/banked_dp_ram.sv
// Banked simple-dual-port RAM. Upper address bits pick a bank, lower bits a
// word. Registered read with valid pulse, write-first forwarding on an exact
// address collision, out-of-range bank detection, and a post-reset clear
// that zeroes one word per cycle in every bank in parallel.
module banked_dp_ram #(
  parameter int DATA_W      = 12,
  parameter int WORD_ADDR_W = 10,
  parameter int NUM_BANKS   = 4,
  localparam int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int ADDR_W     = WORD_ADDR_W + BANK_W
) (
  input logic             clk,
  input logic             rst,
  banked_dp_ram_if.slave  bus
);
  localparam int DEPTH = 2**WORD_ADDR_W;
  // Bank count widened by one bit so 16 banks still fits for the compare.
  localparam logic [BANK_W:0] NB = (BANK_W+1)'(NUM_BANKS);

  typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_READY} state_t;

  state_t                  r_state, w_state_nxt;
  logic [WORD_ADDR_W-1:0]  r_clr_cnt;
  logic                    w_busy;

  logic [DATA_W-1:0]       r_data_out;
  logic                    r_data_valid;
  logic                    r_wr_err;
  logic                    r_rd_err;
  logic [15:0]             r_coll_cnt;

  logic [BANK_W-1:0]       w_wr_bank, w_rd_bank;
  logic [WORD_ADDR_W-1:0]  w_wr_word, w_rd_word;
  logic                    w_wr_bank_ok, w_rd_bank_ok;
  logic                    w_wr_ok, w_rd_ok, w_wr_bad, w_rd_bad, w_collide;
  logic [NUM_BANKS-1:0][DATA_W-1:0] w_bank_rd;
  logic [DATA_W-1:0]       w_rd_word_data;

  assign w_wr_bank = bus.write_address[ADDR_W-1:WORD_ADDR_W];
  assign w_wr_word = bus.write_address[WORD_ADDR_W-1:0];
  assign w_rd_bank = bus.read_address[ADDR_W-1:WORD_ADDR_W];
  assign w_rd_word = bus.read_address[WORD_ADDR_W-1:0];

  assign w_wr_bank_ok = ({1'b0, w_wr_bank} < NB);
  assign w_rd_bank_ok = ({1'b0, w_rd_bank} < NB);

  // Requests are only honoured once the clear has finished.
  assign w_wr_ok   = !w_busy && bus.write_enable &&  w_wr_bank_ok;
  assign w_wr_bad  = !w_busy && bus.write_enable && !w_wr_bank_ok;
  assign w_rd_ok   = !w_busy && bus.read_enable  &&  w_rd_bank_ok;
  assign w_rd_bad  = !w_busy && bus.read_enable  && !w_rd_bank_ok;
  assign w_collide = w_wr_ok && w_rd_ok && (bus.write_address == bus.read_address);

  // Controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_RESET;
    else     r_state <= w_state_nxt;
  end

  // Next state: RESET clears word 0 on the first edge after release, so the
  // whole clear takes exactly DEPTH edges whichever busy state it starts in.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b1;
    case (r_state)
      ST_RESET, ST_CLEAR: w_state_nxt = (&r_clr_cnt) ? ST_READY : ST_CLEAR;
      ST_READY:           w_busy = 1'b0;
      default:            w_state_nxt = ST_RESET;
    endcase
  end

  // Clear word pointer; wraps back to 0 as the last word is cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_clr_cnt <= '0;
    else if (w_busy) r_clr_cnt <= r_clr_cnt + 1'b1;
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    localparam logic [BANK_W:0] BANK_ID = (BANK_W+1)'(b);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_sel;
    assign w_sel = ({1'b0, w_wr_bank} == BANK_ID);

    // Bank storage: clear pattern while busy, else the addressed write.
    always_ff @(posedge clk) begin
      if (w_busy)                r_mem[r_clr_cnt] <= '0;
      else if (w_wr_ok && w_sel) r_mem[w_wr_word] <= bus.data_in;
    end

    assign w_bank_rd[b] = r_mem[w_rd_word];
  end

  // Bank select for the read port.
  always_comb begin
    w_rd_word_data = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      if ({1'b0, w_rd_bank} == (BANK_W+1)'(b)) w_rd_word_data = w_bank_rd[b];
  end

  // Read result and single-cycle status pulses; data_out holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_wr_err     <= 1'b0;
      r_rd_err     <= 1'b0;
    end else begin
      r_data_valid <= w_rd_ok;
      r_wr_err     <= w_wr_bad;
      r_rd_err     <= w_rd_bad;
      if (w_collide)    r_data_out <= bus.data_in;
      else if (w_rd_ok) r_data_out <= w_rd_word_data;
    end
  end

  // Saturating collision counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   r_coll_cnt <= '0;
    else if (w_collide && r_coll_cnt != 16'hFFFF) r_coll_cnt <= r_coll_cnt + 16'd1;
  end

  assign bus.data_out        = r_data_out;
  assign bus.data_valid      = r_data_valid;
  assign bus.init_busy       = w_busy;
  assign bus.wr_err          = r_wr_err;
  assign bus.rd_err          = r_rd_err;
  assign bus.collision_count = r_coll_cnt;
endmodule

// File: tb/tb_banked_dp_ram.sv
// Directed bench for banked_dp_ram: a 4-bank instance for the main function
// and a 3-bank instance for out-of-range bank handling, fed the same stimulus.
module tb_banked_dp_ram;
  logic clk = 1'b0;
  logic rst;
  logic [11:0] t_din, t_wa, t_ra;
  logic        t_we, t_re;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  banked_dp_ram_if #(.DATA_W(12), .ADDR_W(12)) if4 ();
  banked_dp_ram_if #(.DATA_W(12), .ADDR_W(12)) if3 ();

  assign if4.data_in = t_din;  assign if4.write_address = t_wa;
  assign if4.write_enable = t_we; assign if4.read_address = t_ra;
  assign if4.read_enable = t_re;
  assign if3.data_in = t_din;  assign if3.write_address = t_wa;
  assign if3.write_enable = t_we; assign if3.read_address = t_ra;
  assign if3.read_enable = t_re;

  banked_dp_ram #(.DATA_W(12), .WORD_ADDR_W(10), .NUM_BANKS(4))
    u_d4 (.clk(clk), .rst(rst), .bus(if4));
  banked_dp_ram #(.DATA_W(12), .WORD_ADDR_W(10), .NUM_BANKS(3))
    u_d3 (.clk(clk), .rst(rst), .bus(if3));

  typedef struct {
    logic        we;
    logic [11:0] wa;
    logic [11:0] din;
    logic        re;
    logic [11:0] ra;
    logic        exp_dv;
    logic [11:0] exp_do;
    logic [15:0] exp_cc;
  } vec_t;

  vec_t tbl [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic we, input logic [11:0] wa, input logic [11:0] din,
                       input logic re, input logic [11:0] ra);
    t_we = we; t_wa = wa; t_din = din; t_re = re; t_ra = ra;
  endtask

  task automatic idle();
    drive(1'b0, 12'h000, 12'h000, 1'b0, 12'h000);
  endtask

  // Counts edges until init_busy drops (bounded). Optionally fires one
  // write+read at cycle 10 of the clear and checks it is ignored.
  task automatic wait_clear(input bit with_req, output int n);
    n = 0;
    while (if4.init_busy && n < 2000) begin
      if (with_req && n == 10) drive(1'b1, 12'hC20, 12'hFFF, 1'b1, 12'hC20);
      else idle();
      step();
      n++;
      if (with_req && n == 11) begin
        check("clr_req d4 dv",   if4.data_valid, 1'b0);
        check("clr_req d4 cc",   if4.collision_count, 16'h0);
        check("clr_req d3 werr", if3.wr_err, 1'b0);
        check("clr_req d3 rerr", if3.rd_err, 1'b0);
      end
    end
    idle();
  endtask

  initial begin
    int n;
    // we, wa, din, re, ra, exp_dv, exp_do, exp_cc
    tbl[0]  = '{1'b0, 12'h000, 12'h000, 1'b1, 12'h7FF, 1'b1, 12'h000, 16'd0};
    tbl[1]  = '{1'b1, 12'h005, 12'hABC, 1'b0, 12'h000, 1'b0, 12'h000, 16'd0};
    tbl[2]  = '{1'b1, 12'hC05, 12'h123, 1'b0, 12'h000, 1'b0, 12'h000, 16'd0};
    tbl[3]  = '{1'b0, 12'h000, 12'h000, 1'b1, 12'h005, 1'b1, 12'hABC, 16'd0};
    tbl[4]  = '{1'b0, 12'h000, 12'h000, 1'b1, 12'hC05, 1'b1, 12'h123, 16'd0};
    tbl[5]  = '{1'b0, 12'h000, 12'h000, 1'b1, 12'hC20, 1'b1, 12'h000, 16'd0};
    tbl[6]  = '{1'b1, 12'h010, 12'h111, 1'b1, 12'h005, 1'b1, 12'hABC, 16'd0};
    tbl[7]  = '{1'b1, 12'h010, 12'h222, 1'b1, 12'h010, 1'b1, 12'h222, 16'd1};
    tbl[8]  = '{1'b0, 12'h000, 12'h000, 1'b0, 12'h000, 1'b0, 12'h222, 16'd1};
    tbl[9]  = '{1'b0, 12'h000, 12'h000, 1'b1, 12'h010, 1'b1, 12'h222, 16'd1};
    tbl[10] = '{1'b1, 12'h011, 12'h333, 1'b1, 12'h011, 1'b1, 12'h333, 16'd2};
    tbl[11] = '{1'b1, 12'h011, 12'h444, 1'b1, 12'h010, 1'b1, 12'h222, 16'd2};
    tbl[12] = '{1'b0, 12'h000, 12'h000, 1'b1, 12'h011, 1'b1, 12'h444, 16'd2};
    tbl[13] = '{1'b1, 12'h805, 12'h555, 1'b1, 12'h005, 1'b1, 12'hABC, 16'd2};
    tbl[14] = '{1'b0, 12'h000, 12'h000, 1'b1, 12'h805, 1'b1, 12'h555, 16'd2};
    tbl[15] = '{1'b1, 12'h805, 12'h666, 1'b0, 12'h805, 1'b0, 12'h555, 16'd2};
    tbl[16] = '{1'b0, 12'h000, 12'h000, 1'b1, 12'h805, 1'b1, 12'h666, 16'd2};

    // Reset for 3 cycles, then the clear with an ignored request at cycle 10.
    rst = 1'b1;
    idle();
    repeat (3) step();
    check("rst dout", if4.data_out, 12'h000);
    check("rst dv",   if4.data_valid, 1'b0);
    check("rst werr", if4.wr_err, 1'b0);
    check("rst rerr", if4.rd_err, 1'b0);
    check("rst cc",   if4.collision_count, 16'h0);
    check("rst busy", if4.init_busy, 1'b1);
    rst = 1'b0;
    wait_clear(1'b1, n);
    check("clear length", n, 1024);

    // Main function vectors on the 4-bank instance.
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].din, tbl[i].re, tbl[i].ra);
      step();
      check($sformatf("vec%0d dv", i),   if4.data_valid, tbl[i].exp_dv);
      check($sformatf("vec%0d dout", i), if4.data_out, tbl[i].exp_do);
      check($sformatf("vec%0d cc", i),   if4.collision_count, tbl[i].exp_cc);
      check($sformatf("vec%0d err", i),  {if4.wr_err, if4.rd_err}, 2'b00);
    end

    // Out-of-range bank on the 3-bank instance.
    drive(1'b1, 12'h000, 12'h5A5, 1'b0, 12'h000); step();
    check("b3 wr ok werr", if3.wr_err, 1'b0);
    drive(1'b0, 12'h000, 12'h000, 1'b1, 12'h000); step();
    check("b3 rd0 dv",   if3.data_valid, 1'b1);
    check("b3 rd0 dout", if3.data_out, 12'h5A5);
    drive(1'b1, 12'hC00, 12'hFFF, 1'b0, 12'h000); step();
    check("b3 badwr werr",    if3.wr_err, 1'b1);
    check("b3 badwr d4 werr", if4.wr_err, 1'b0);
    check("b3 badwr dv",      if3.data_valid, 1'b0);
    idle(); step();
    check("b3 werr pulse", if3.wr_err, 1'b0);
    drive(1'b0, 12'h000, 12'h000, 1'b1, 12'hC00); step();
    check("b3 badrd rerr", if3.rd_err, 1'b1);
    check("b3 badrd dv",   if3.data_valid, 1'b0);
    check("b3 badrd dout", if3.data_out, 12'h5A5);
    idle(); step();
    check("b3 rerr pulse", if3.rd_err, 1'b0);
    drive(1'b0, 12'h000, 12'h000, 1'b1, 12'h000); step();
    check("b3 bank0 kept dv",   if3.data_valid, 1'b1);
    check("b3 bank0 kept dout", if3.data_out, 12'h5A5);
    check("d4 bank0 kept dout", if4.data_out, 12'h5A5);
    drive(1'b0, 12'h000, 12'h000, 1'b1, 12'h800); step();
    check("b3 bank2 dv",   if3.data_valid, 1'b1);
    check("b3 bank2 rerr", if3.rd_err, 1'b0);
    check("b3 bank2 dout", if3.data_out, 12'h000);
    idle();

    // Reset in the middle of a clear restarts it from word 0.
    rst = 1'b1; repeat (2) step(); rst = 1'b0;
    idle();
    repeat (500) step();
    rst = 1'b1;
    #1;
    check("midrst busy", if4.init_busy, 1'b1);
    check("midrst cc",   if4.collision_count, 16'h0);
    check("midrst dout", if4.data_out, 12'h000);
    @(negedge clk); step();
    rst = 1'b0;
    wait_clear(1'b0, n);
    check("midrst clear length", n, 1024);

    // Collision counter saturation.
    for (int i = 1; i <= 65537; i++) begin
      drive(1'b1, 12'h010, 12'(i), 1'b1, 12'h010);
      step();
      if (i == 65534) check("sat cc 65534", if4.collision_count, 16'hFFFE);
      if (i == 65535) check("sat cc 65535", if4.collision_count, 16'hFFFF);
    end
    check("sat cc final",   if4.collision_count, 16'hFFFF);
    check("sat dout final", if4.data_out, 12'h001);
    idle(); step();
    drive(1'b0, 12'h000, 12'h000, 1'b1, 12'h010); step();
    check("sat readback", if4.data_out, 12'h001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
